// File: rtl/instruction_fetch_controller_if.sv
// Fetch-controller bundle: pipeline control, debug read port, ROM port and IF/ID outputs.
//   master : the fetch controller (drives ROM address, IF/ID, debug ack/data, fault)
//   slave  : the surrounding pipeline / ROM / debugger
interface instruction_fetch_controller_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  stall_i;
  logic                  redirect_i;
  logic [DATA_WIDTH-1:0] redirect_pc_i;
  logic                  dbg_req_i;
  logic [DATA_WIDTH-1:0] dbg_addr_i;
  logic                  dbg_ack_o;
  logic [DATA_WIDTH-1:0] dbg_data_o;
  logic [DATA_WIDTH-1:0] mem_address_o;
  logic [DATA_WIDTH-1:0] mem_instruction_i;
  logic                  if_valid_o;
  logic [DATA_WIDTH-1:0] if_pc_o;
  logic [DATA_WIDTH-1:0] if_pc_plus4_o;
  logic [DATA_WIDTH-1:0] if_instruction_o;
  logic                  addr_fault_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, dbg_req_i, dbg_addr_i, mem_instruction_i,
    output dbg_ack_o, dbg_data_o, mem_address_o, if_valid_o, if_pc_o, if_pc_plus4_o,
           if_instruction_o, addr_fault_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, dbg_req_i, dbg_addr_i, mem_instruction_i,
    input  dbg_ack_o, dbg_data_o, mem_address_o, if_valid_o, if_pc_o, if_pc_plus4_o,
           if_instruction_o, addr_fault_o
  );
endinterface

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, addresses the combinational program ROM,
// fills the IF/ID register, honours stall and redirect, shares the ROM port with a
// debug read while the pipeline is stalled or halted, and flags PC faults.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : instruction_fetch_controller_if.master (control, debug, ROM, IF/ID, fault)
module instruction_fetch_controller #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(32'h0040_0000),
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(32'h0040_0000)
) (
  input  logic                           clk,
  input  logic                           reset,
  instruction_fetch_controller_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] TEXT_END = TEXT_BASE + DATA_WIDTH'(4 * MEMORY_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_DBG  = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  state_e                ret_q, ret_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [DATA_WIDTH-1:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [DATA_WIDTH-1:0] if_instruction_q, if_instruction_d;
  logic                  dbg_ack_q, dbg_ack_d;
  logic [DATA_WIDTH-1:0] dbg_data_q, dbg_data_d;
  logic                  addr_fault_q, addr_fault_d;
  logic                  pc_legal_c;

  // Word-aligned and inside the text window (unsigned compare).
  assign pc_legal_c = (pc_q[1:0] == 2'b00) && (pc_q >= TEXT_BASE) && (pc_q < TEXT_END);

  // The debug port owns the ROM address only during its single DBG cycle.
  assign bus.mem_address_o = (state_q == S_DBG) ? bus.dbg_addr_i : pc_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    ret_d            = ret_q;
    pc_d             = pc_q;
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    if_pc_plus4_d    = if_pc_plus4_q;
    if_instruction_d = if_instruction_q;
    dbg_ack_d        = 1'b0;
    dbg_data_d       = dbg_data_q;
    addr_fault_d     = addr_fault_q;

    unique case (state_q)
      S_BOOT: begin
        if_valid_d = 1'b0;
        state_d    = S_RUN;
      end

      S_RUN: begin
        if (bus.redirect_i) begin
          // Redirect flushes IF/ID and beats stall; target is checked on its fetch.
          pc_d       = bus.redirect_pc_i;
          if_valid_d = 1'b0;
        end else if (bus.stall_i) begin
          if (bus.dbg_req_i) begin
            state_d = S_DBG;
            ret_d   = S_RUN;
          end
        end else if (!pc_legal_c) begin
          addr_fault_d = 1'b1;
          if_valid_d   = 1'b0;
          state_d      = S_HALT;
        end else begin
          if_instruction_d = bus.mem_instruction_i;
          if_pc_d          = pc_q;
          if_pc_plus4_d    = pc_q + PC_STEP;
          if_valid_d       = 1'b1;
          pc_d             = pc_q + PC_STEP;
        end
      end

      S_DBG: begin
        dbg_data_d = bus.mem_instruction_i;
        dbg_ack_d  = 1'b1;
        state_d    = ret_q;
        // A redirect arriving during a stalled-pipeline debug read must not be lost.
        if ((ret_q == S_RUN) && bus.redirect_i) begin
          pc_d       = bus.redirect_pc_i;
          if_valid_d = 1'b0;
        end
      end

      S_HALT: begin
        if_valid_d   = 1'b0;
        addr_fault_d = 1'b1;
        if (bus.dbg_req_i) begin
          state_d = S_DBG;
          ret_d   = S_HALT;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_BOOT;
      ret_q            <= S_RUN;
      pc_q             <= RESET_PC;
      if_valid_q       <= 1'b0;
      if_pc_q          <= RESET_PC;
      if_pc_plus4_q    <= RESET_PC + PC_STEP;
      if_instruction_q <= '0;
      dbg_ack_q        <= 1'b0;
      dbg_data_q       <= '0;
      addr_fault_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      ret_q            <= ret_d;
      pc_q             <= pc_d;
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      if_pc_plus4_q    <= if_pc_plus4_d;
      if_instruction_q <= if_instruction_d;
      dbg_ack_q        <= dbg_ack_d;
      dbg_data_q       <= dbg_data_d;
      addr_fault_q     <= addr_fault_d;
    end
  end

  assign bus.if_valid_o       = if_valid_q;
  assign bus.if_pc_o          = if_pc_q;
  assign bus.if_pc_plus4_o    = if_pc_plus4_q;
  assign bus.if_instruction_o = if_instruction_q;
  assign bus.dbg_ack_o        = dbg_ack_q;
  assign bus.dbg_data_o       = dbg_data_q;
  assign bus.addr_fault_o     = addr_fault_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller; ROM word k holds value k.
module tb_instruction_fetch_controller;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  instruction_fetch_controller_if #(.DATA_WIDTH(32)) ifc ();

  instruction_fetch_controller #(
    .DATA_WIDTH  (32),
    .MEMORY_DEPTH(32),
    .TEXT_BASE   (32'h0040_0000),
    .RESET_PC    (32'h0040_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.master)
  );

  // 32-word ROM, word k = k, decoded from byte-address bits [6:2].
  assign ifc.mem_instruction_i = 32'(ifc.mem_address_o[6:2]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
    check({tag, ".valid"}, 32'(ifc.if_valid_o), 32'(v));
    check({tag, ".pc"}, ifc.if_pc_o, pc);
    check({tag, ".pc4"}, ifc.if_pc_plus4_o, pc + 32'd4);
    check({tag, ".instr"}, ifc.if_instruction_o, instr);
  endtask

  initial begin
    reset             = 1'b0;
    ifc.stall_i       = 1'b0;
    ifc.redirect_i    = 1'b0;
    ifc.redirect_pc_i = '0;
    ifc.dbg_req_i     = 1'b0;
    ifc.dbg_addr_i    = '0;
    tick();

    // Reset values
    check_ifid("rst", 1'b0, 32'h0040_0000, 32'd0);
    check("rst.fault", 32'(ifc.addr_fault_o), 32'd0);
    check("rst.ack", 32'(ifc.dbg_ack_o), 32'd0);
    check("rst.dbgdata", ifc.dbg_data_o, 32'd0);
    check("rst.addr", ifc.mem_address_o, 32'h0040_0000);

    // 1: BOOT cycle then sequential fetch
    reset = 1'b1;
    tick();
    check("boot.valid", 32'(ifc.if_valid_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_ifid("seq", 1'b1, 32'h0040_0000 + 32'(4 * k), 32'(k));
    end
    check("seq.addr", ifc.mem_address_o, 32'h0040_000C);

    // 2: stall three cycles at if_pc 0x00400008
    ifc.stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_ifid("stall", 1'b1, 32'h0040_0008, 32'd2);
      check("stall.addr", ifc.mem_address_o, 32'h0040_000C);
    end
    ifc.stall_i = 1'b0;
    tick();
    check_ifid("resume", 1'b1, 32'h0040_000C, 32'd3);

    // 3: redirect wins over stall
    ifc.stall_i       = 1'b1;
    ifc.redirect_i    = 1'b1;
    ifc.redirect_pc_i = 32'h0040_0040;
    tick();
    check("redir.flush", 32'(ifc.if_valid_o), 32'd0);
    check("redir.addr", ifc.mem_address_o, 32'h0040_0040);
    ifc.stall_i    = 1'b0;
    ifc.redirect_i = 1'b0;
    tick();
    check_ifid("redir.tgt", 1'b1, 32'h0040_0040, 32'd16);

    // 4: debug read while stalled
    ifc.stall_i    = 1'b1;
    ifc.dbg_req_i  = 1'b1;
    ifc.dbg_addr_i = 32'h0040_0010;
    tick();
    check("dbg.grant_addr", ifc.mem_address_o, 32'h0040_0010);
    check("dbg.ack_early", 32'(ifc.dbg_ack_o), 32'd0);
    tick();
    check("dbg.ack", 32'(ifc.dbg_ack_o), 32'd1);
    check("dbg.data", ifc.dbg_data_o, 32'd4);
    check_ifid("dbg.ifid", 1'b1, 32'h0040_0040, 32'd16);
    check("dbg.ret_addr", ifc.mem_address_o, 32'h0040_0044);
    ifc.dbg_req_i = 1'b0;
    tick();
    check("dbg.ack_pulse", 32'(ifc.dbg_ack_o), 32'd0);
    ifc.stall_i = 1'b0;

    // 5: debug request without stall is not granted; run off the end of the text
    ifc.dbg_req_i  = 1'b1;
    ifc.dbg_addr_i = 32'h0040_0000;
    tick();
    check_ifid("nogrant", 1'b1, 32'h0040_0044, 32'd17);
    check("nogrant.ack", 32'(ifc.dbg_ack_o), 32'd0);
    check("nogrant.addr", ifc.mem_address_o, 32'h0040_0048);
    ifc.dbg_req_i = 1'b0;
    for (int k = 1; k < 15; k++) begin
      tick();
      check("run.instr", ifc.if_instruction_o, 32'(17 + k));
    end
    check_ifid("last", 1'b1, 32'h0040_007C, 32'd31);
    check("last.fault", 32'(ifc.addr_fault_o), 32'd0);
    tick();
    check("oob.fault", 32'(ifc.addr_fault_o), 32'd1);
    check("oob.valid", 32'(ifc.if_valid_o), 32'd0);
    check("oob.pc_hold", ifc.if_pc_o, 32'h0040_007C);
    ifc.redirect_i    = 1'b1;
    ifc.redirect_pc_i = 32'h0040_0000;
    tick();
    check("halt.redir_ign", ifc.mem_address_o, 32'h0040_0080);
    check("halt.fault", 32'(ifc.addr_fault_o), 32'd1);
    check("halt.valid", 32'(ifc.if_valid_o), 32'd0);
    ifc.redirect_i = 1'b0;
    ifc.dbg_req_i  = 1'b1;
    ifc.dbg_addr_i = 32'h0040_0008;
    tick();
    check("hdbg.addr", ifc.mem_address_o, 32'h0040_0008);
    tick();
    check("hdbg.ack", 32'(ifc.dbg_ack_o), 32'd1);
    check("hdbg.data", ifc.dbg_data_o, 32'd2);
    ifc.dbg_req_i = 1'b0;
    tick();
    check("hdbg.ack_pulse", 32'(ifc.dbg_ack_o), 32'd0);
    check("hdbg.fault", 32'(ifc.addr_fault_o), 32'd1);
    check("hdbg.valid", 32'(ifc.if_valid_o), 32'd0);
    reset = 1'b0;
    #1;
    check("clr.fault", 32'(ifc.addr_fault_o), 32'd0);
    check("clr.pc", ifc.if_pc_o, 32'h0040_0000);
    check("clr.addr", ifc.mem_address_o, 32'h0040_0000);
    reset = 1'b1;

    // 6a: misaligned redirect target faults on its fetch
    tick();
    tick();
    check_ifid("mis.first", 1'b1, 32'h0040_0000, 32'd0);
    ifc.redirect_i    = 1'b1;
    ifc.redirect_pc_i = 32'h0040_0002;
    tick();
    check("mis.flush", 32'(ifc.if_valid_o), 32'd0);
    check("mis.nofault_yet", 32'(ifc.addr_fault_o), 32'd0);
    ifc.redirect_i = 1'b0;
    tick();
    check("mis.fault", 32'(ifc.addr_fault_o), 32'd1);
    check("mis.valid", 32'(ifc.if_valid_o), 32'd0);
    check("mis.addr", ifc.mem_address_o, 32'h0040_0002);

    // 6b: reset during DBG aborts without an ack
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    tick();
    ifc.stall_i    = 1'b1;
    ifc.dbg_req_i  = 1'b1;
    ifc.dbg_addr_i = 32'h0040_0014;
    tick();
    check("rdbg.addr", ifc.mem_address_o, 32'h0040_0014);
    reset = 1'b0;
    #1;
    check("rdbg.ack0", 32'(ifc.dbg_ack_o), 32'd0);
    check("rdbg.addr_rst", ifc.mem_address_o, 32'h0040_0000);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rdbg.ack_hold", 32'(ifc.dbg_ack_o), 32'd0);
    end
    ifc.stall_i   = 1'b0;
    ifc.dbg_req_i = 1'b0;
    reset         = 1'b1;
    tick();
    check("rboot.valid", 32'(ifc.if_valid_o), 32'd0);
    check("rboot.ack", 32'(ifc.dbg_ack_o), 32'd0);
    tick();
    check_ifid("rboot.fetch", 1'b1, 32'h0040_0000, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
